store_checker: RTL

- Synthesizable self-check monitor on the single-cycle core's data-memory store bus; replaces ad-hoc pass/fail checks in simulation benches and runs on FPGA.
- Compares an ordered sequence of up to DEPTH expected stores (address and data), ignores stores to a scratch window, and enforces a cycle timeout.
- Reports pass, fail or timeout with diagnostic capture.

---
 rtl/store_checker.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/store_checker.sv
// store_checker: watches the core's data-memory store bus and compares it
// against an ordered table of expected (address, data) stores. Stores to a
// scratch window are skipped, and an optional cycle limit turns a stalled
// program into a timeout. The verdict is sticky until start or reset.
//
// Interface timing: mem_write is a single-cycle strobe. A store is taken on
// every rising edge where mem_write=1; there is no back-pressure. cfg_we and
// start are likewise sampled on the rising edge. cfg_we acts only in IDLE,
// and start acts in every state except RUN.
module store_checker #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int IGN_BASE  = 96,
    parameter int IGN_SIZE  = 4,
    parameter int TIMEOUT_W = 16,
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_write,
    input  logic [ADDR_W-1:0]    data_adr,
    input  logic [DATA_W-1:0]    write_data,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0]    cfg_adr,
    input  logic [DATA_W-1:0]    cfg_data,
    input  logic [CNT_W-1:0]     cfg_count,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [1:0]           fail_code,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [ADDR_W-1:0]    fail_adr,
    output logic [DATA_W-1:0]    fail_data,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TOUT = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] IGN_LO = ADDR_W'(IGN_BASE);
    localparam logic [ADDR_W-1:0] IGN_SZ = ADDR_W'(IGN_SIZE);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);

    state_t state_q, state_d;

    logic [ADDR_W-1:0]    tbl_adr  [DEPTH];
    logic [DATA_W-1:0]    tbl_data [DEPTH];
    logic [CNT_W-1:0]     cnt_lim;
    logic [TIMEOUT_W-1:0] tout_lim;
    logic [TIMEOUT_W-1:0] cyc_q;
    logic [TIMEOUT_W-1:0] cyc_inc;

    logic                 arm;
    logic                 in_window;
    logic                 adr_ok;
    logic                 data_ok;
    logic                 store_hit;
    logic                 store_bad;
    logic                 completing;
    logic                 limit_hit;
    logic [CNT_W-1:0]     match_inc;
    logic [CNT_W-1:0]     cnt_sel;
    logic [1:0]           code_d;

    // Datapath decode: window test, compare against the next expected entry, cycle limit.
    always_comb begin
        arm        = start && (state_q != S_RUN);
        in_window  = (IGN_SIZE != 0) && (data_adr >= IGN_LO) && ((data_adr - IGN_LO) < IGN_SZ);
        adr_ok     = (data_adr == tbl_adr[match_cnt[IDX_W-1:0]]);
        data_ok    = (write_data == tbl_data[match_cnt[IDX_W-1:0]]);
        store_hit  = mem_write && !in_window && adr_ok && data_ok;
        store_bad  = mem_write && !in_window && !(adr_ok && data_ok);
        match_inc  = match_cnt + CNT_W'(1);
        completing = store_hit && (match_inc == cnt_lim);
        // Saturate instead of wrapping so a huge limit can never be skipped past.
        cyc_inc    = (cyc_q == '1) ? cyc_q : cyc_q + TIMEOUT_W'(1);
        limit_hit  = (tout_lim != '0) && (cyc_inc == tout_lim);
        // A count larger than the table is treated as the full table.
        cnt_sel    = (cfg_count > CNT_MAX) ? CNT_MAX : cfg_count;
    end

    // Next-state logic: a completing store beats the limit, the limit beats a mismatch.
    always_comb begin
        state_d = state_q;
        code_d  = 2'd0;
        case (state_q)
            S_RUN: begin
                if (completing) begin
                    state_d = S_PASS;
                end else if (limit_hit) begin
                    state_d = S_TOUT;
                    code_d  = 2'd3;
                end else if (store_bad) begin
                    state_d = S_FAIL;
                    code_d  = adr_ok ? 2'd2 : 2'd1;
                end
            end
            default: begin
                if (start) begin
                    state_d = (cfg_count == '0) ? S_PASS : S_RUN;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Table, run counters and failure diagnostics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_adr[i]  <= '0;
                tbl_data[i] <= '0;
            end
            cnt_lim   <= '0;
            tout_lim  <= '0;
            cyc_q     <= '0;
            match_cnt <= '0;
            fail_code <= 2'd0;
            fail_adr  <= '0;
            fail_data <= '0;
        end else begin
            // Written in the same edge as start, so a run started now sees the new entry.
            if (state_q == S_IDLE && cfg_we) begin
                tbl_adr[cfg_idx]  <= cfg_adr;
                tbl_data[cfg_idx] <= cfg_data;
            end
            if (arm) begin
                cnt_lim   <= cnt_sel;
                tout_lim  <= cfg_timeout;
                cyc_q     <= '0;
                match_cnt <= '0;
                fail_code <= 2'd0;
                fail_adr  <= '0;
                fail_data <= '0;
            end else if (state_q == S_RUN) begin
                cyc_q <= cyc_inc;
                if (store_hit) begin
                    match_cnt <= match_inc;
                end
                if (state_d == S_FAIL) begin
                    fail_code <= code_d;
                    fail_adr  <= data_adr;
                    fail_data <= write_data;
                end else if (state_d == S_TOUT) begin
                    fail_code <= code_d;
                    fail_adr  <= '0;
                    fail_data <= '0;
                end
            end
        end
    end

    assign busy  = (state_q == S_RUN);
    assign pass  = (state_q == S_PASS);
    assign fail  = (state_q == S_FAIL) || (state_q == S_TOUT);
    assign done  = pass || fail;
    assign state = state_q;

endmodule
